// File: rtl/uart_tx.sv
// Purpose: serial UART transmitter, LSB first, 1 start, 8 data, optional parity, 1-2 stop bits.
// Latency: tx drops on the accept edge; frame is (1+8+par+stop)*CLKS_PER_BIT cycles, +1 idle cycle between frames.
// Backpressure: tx_start is a level request taken only while tx_ready is high; requests while busy are dropped.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-high reset; abandons any frame and forces tx high at once
//   tx_start - level request to send tx_data
//   tx_data  - byte to send, sampled only on the accept edge
//   tx       - serial line, idles high
//   tx_ready - high exactly while idle
//   tx_done  - one-cycle pulse on the edge that ends the last stop cell
module uart_tx #(
  parameter int CLKS_PER_BIT = 208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;    // data bit index in DATA, stop cell index in STOP
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_tx;
  logic             r_ready;
  logic             r_done;
  logic             w_cell_end;

  assign w_cell_end = (r_cnt == CNT_LAST);

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign tx_done  = r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The cycle counter only runs inside a frame and is back at 0 whenever IDLE is entered.
      if (r_state != S_IDLE) begin
        r_cnt <= w_cell_end ? '0 : r_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_shift <= tx_data;
            // Parity comes from the byte being latched, so later tx_data changes cannot leak in.
            r_par   <= (PARITY == 1) ? ~(^tx_data) : ^tx_data;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_cell_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_cell_end) begin
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (PARITY != 0) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              // Present the next bit on the same edge the shift happens.
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_cell_end) begin
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_cell_end) begin
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: checks four uart_tx configurations sharing one stimulus stream against a frame-level model.
// Latency: model predicts tx/tx_ready/tx_done every cycle from accept time and bit-cell arithmetic.
// Backpressure: requests while busy are expected to be dropped; held requests restart one cycle after done.
module tb_uart_tx;

  logic       clock;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] tx_w;
  logic [3:0] rdy_w;
  logic [3:0] done_w;

  int n_pass;
  int n_total;
  int busy_cyc[4];
  int done_cnt[4];

  // Reference model state: frame bits in send order and cycles elapsed since accept.
  logic        m_busy[4];
  logic        m_done[4];
  int          m_t[4];
  logic [11:0] m_bits[4];

  uart_tx #(.CLKS_PER_BIT(4),   .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clock(clock), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[0]), .tx_ready(rdy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(4),   .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clock(clock), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[1]), .tx_ready(rdy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(4),   .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .clock(clock), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[2]), .tx_ready(rdy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.CLKS_PER_BIT(208), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .clock(clock), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx(tx_w[3]), .tx_ready(rdy_w[3]), .tx_done(done_w[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int cpb_of(input int k);
    return (k == 3) ? 208 : 4;
  endfunction

  function automatic int par_of(input int k);
    case (k)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int nbits_of(input int k);
    return 9 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
  endfunction

  // Line levels in send order: start, data LSB first, parity, then stop (all remaining bits high).
  function automatic logic [11:0] frame_bits(input int k, input logic [7:0] d);
    logic [11:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    if (par_of(k) == 2) b[9] = ^d;
    if (par_of(k) == 1) b[9] = ~(^d);
    return b;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_t[k]    <= 0;
      end else if (m_busy[k]) begin
        if (m_t[k] + 1 == nbits_of(k) * cpb_of(k)) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
        end else begin
          m_t[k]    <= m_t[k] + 1;
          m_done[k] <= 1'b0;
        end
      end else begin
        m_done[k] <= 1'b0;
        if (tx_start) begin
          m_busy[k] <= 1'b1;
          m_t[k]    <= 0;
          m_bits[k] <= frame_bits(k, tx_data);
        end
      end
    end
  end

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic exp_tx;
    for (int k = 0; k < 4; k++) begin
      exp_tx = m_busy[k] ? m_bits[k][m_t[k] / cpb_of(k)] : 1'b1;
      chk({tag, "_tx"},    k, int'(tx_w[k]),   int'(exp_tx));
      chk({tag, "_ready"}, k, int'(rdy_w[k]),  int'(!m_busy[k]));
      chk({tag, "_done"},  k, int'(done_w[k]), int'(m_done[k]));
      if (!rdy_w[k]) busy_cyc[k]++;
      if (done_w[k]) done_cnt[k]++;
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clock);
      check_all(tag);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 4; k++) begin
      busy_cyc[k] = 0;
      done_cnt[k] = 0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((m_busy[0] || m_busy[1] || m_busy[2] || m_busy[3] || rdy_w != 4'hF) && cyc < 3000) begin
      @(negedge clock);
      check_all(tag);
      cyc++;
    end
    if (cyc >= 3000) begin
      n_total++;
      $error("FAIL %s_timeout observed=%0d cycles expected=idle", tag, cyc);
    end
    run(2, tag);
  endtask

  // One-cycle request, then drain; frame lengths per configuration are checked from the DUT's own outputs.
  task automatic single_frame(input logic [7:0] d, input string tag);
    clear_counts();
    @(negedge clock);
    check_all(tag);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clock);
    check_all(tag);
    tx_start = 1'b0;
    wait_idle(tag);
    chk({tag, "_len"},  0, busy_cyc[0], 40);
    chk({tag, "_len"},  1, busy_cyc[1], 44);
    chk({tag, "_len"},  2, busy_cyc[2], 48);
    chk({tag, "_len"},  3, busy_cyc[3], 2080);
    for (int k = 0; k < 4; k++) chk({tag, "_ndone"}, k, done_cnt[k], 1);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    reset    = 1'b1;
    clear_counts();
    run(3, "reset");
    reset = 1'b0;
    run(3, "post_reset");

    single_frame(8'h55, "b55");
    single_frame(8'h41, "b41");

    // Held request: each configuration repeats frames with one idle-high cycle between them.
    clear_counts();
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    run(300, "held");
    chk("held_ndone", 0, done_cnt[0], 300 / 41);
    tx_start = 1'b0;
    wait_idle("held_drain");

    // Data change mid-frame must not reach the line.
    @(negedge clock);
    check_all("chg");
    tx_start = 1'b1;
    tx_data  = 8'h12;
    @(negedge clock);
    check_all("chg");
    tx_start = 1'b0;
    run(9, "chg");
    tx_data = 8'hFF;
    wait_idle("chg");

    // Asynchronous reset in the middle of DATA.
    @(negedge clock);
    check_all("arst");
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    @(negedge clock);
    check_all("arst");
    tx_start = 1'b0;
    run(12, "arst");
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("arst_now_tx",    k, int'(tx_w[k]),   1);
      chk("arst_now_ready", k, int'(rdy_w[k]),  1);
      chk("arst_now_done",  k, int'(done_w[k]), 0);
    end
    run(2, "arst_hold");
    reset = 1'b0;
    run(2, "arst_rel");
    single_frame(8'h3C, "b3C");

    // Random bytes with stray requests while busy.
    for (int it = 0; it < 6; it++) begin
      @(negedge clock);
      check_all("rnd");
      tx_start = 1'b1;
      tx_data  = 8'($urandom);
      repeat ($urandom_range(1, 80)) begin
        @(negedge clock);
        check_all("rnd");
        tx_start = ($urandom_range(0, 3) == 0);
        tx_data  = 8'($urandom);
      end
      tx_start = 1'b0;
      wait_idle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
